// File: rtl/time_count_pkg.sv
// Shared constants and BCD helper for the time-of-day counter.
// Hour mode is selected by TIME_COUNT_12H_EN in time_count.
package time_count_pkg;

  localparam logic [7:0] SEC_MAX     = 8'h59;
  localparam logic [7:0] MIN_MAX     = 8'h59;
  localparam logic [7:0] HOUR_MAX_24 = 8'h23;
  localparam logic [7:0] HOUR_MAX_12 = 8'h12;
  localparam logic [7:0] HOUR_MIN_12 = 8'h01;

  localparam logic [7:0] RESET_SEC     = 8'h00;
  localparam logic [7:0] RESET_MIN     = 8'h00;
  localparam logic [7:0] RESET_HOUR_24 = 8'h00;
  localparam logic [7:0] RESET_HOUR_12 = 8'h12;

  // BCD +1 without range wrap; illegal units or tens digits fall back to 0.
  function automatic logic [7:0] bcd_inc(input logic [7:0] value, input logic [3:0] tens_max);
    logic [3:0] units;
    logic [3:0] tens;
    logic [3:0] units_n;
    logic [3:0] tens_n;
    logic       carry;
    units = value[3:0];
    tens  = value[7:4];
    carry = (units == 4'd9);
    units_n = (units >= 4'd9) ? 4'd0 : units + 4'd1;
    if (tens > tens_max)
      tens_n = 4'd0;
    else if (carry)
      tens_n = (tens == tens_max) ? 4'd0 : tens + 4'd1;
    else
      tens_n = tens;
    return {tens_n, units_n};
  endfunction

endpackage

// File: rtl/time_count_bcd_cnt60.sv
// Eight-bit BCD modulo-60 counter used for the seconds and minutes fields.
module bcd_cnt60
  import time_count_pkg::*;
(
  input  logic       CLK,
  input  logic       RESETL,
  input  logic       clr,
  input  logic       inc,
  output logic [7:0] value,
  output logic       wrap
);

  logic [7:0] value_next;

  // Anything at or above 59 (including illegal codes) restarts at 00.
  assign value_next = (value >= SEC_MAX) ? 8'h00 : bcd_inc(value, 4'd5);
  assign wrap       = inc & ~clr & (value == SEC_MAX);

  always_ff @(posedge CLK or negedge RESETL) begin
    if (!RESETL)
      value <= 8'h00;
    else if (clr)
      value <= 8'h00;
    else if (inc)
      value <= value_next;
  end

endmodule

// File: rtl/time_count.sv
// Time-of-day BCD counter: seconds/minutes/hours with manual setting inputs.
// Define TIME_COUNT_12H_EN for 12-hour operation (12, 01 .. 11); default is 24-hour.
module time_count
  import time_count_pkg::*;
(
  input  logic       CLK,
  input  logic       RESETL,
  input  logic       EN1HZ,
  input  logic       sec_resetl,
  input  logic       min_inc,
  input  logic       hour_inc,
  output logic [7:0] SEC,
  output logic [7:0] MIN,
  output logic [7:0] HOUR,
  output logic       CARRY_DAY
);

`ifdef TIME_COUNT_12H_EN
  localparam logic [7:0] HOUR_RESET = RESET_HOUR_12;
  localparam logic [7:0] HOUR_DAY   = HOUR_MAX_12;
`else
  localparam logic [7:0] HOUR_RESET = RESET_HOUR_24;
  localparam logic [7:0] HOUR_DAY   = RESET_HOUR_24;
`endif

  logic       min_inc_d;
  logic       hour_inc_d;
  logic       min_up;
  logic       hour_up;
  logic       sec_clr;
  logic       sec_step;
  logic       sec_carry;
  logic       min_step;
  logic       min_wrap;
  logic       min_carry;
  logic       hour_step;
  logic [7:0] hour_next;

  always_ff @(posedge CLK or negedge RESETL) begin
    if (!RESETL) begin
      min_inc_d  <= 1'b0;
      hour_inc_d <= 1'b0;
    end else begin
      min_inc_d  <= min_inc;
      hour_inc_d <= hour_inc;
    end
  end

  assign min_up  = min_inc & ~min_inc_d;
  assign hour_up = hour_inc & ~hour_inc_d;

  // Holding seconds in clear also suppresses the tick, so no minute carry can leak out.
  assign sec_clr  = ~sec_resetl;
  assign sec_step = EN1HZ & sec_resetl;

  bcd_cnt60 u_sec (
    .CLK    (CLK),
    .RESETL (RESETL),
    .clr    (sec_clr),
    .inc    (sec_step),
    .value  (SEC),
    .wrap   (sec_carry)
  );

  assign min_step = sec_carry | min_up;

  bcd_cnt60 u_min (
    .CLK    (CLK),
    .RESETL (RESETL),
    .clr    (1'b0),
    .inc    (min_step),
    .value  (MIN),
    .wrap   (min_wrap)
  );

  // A manual minute wrap must not ripple into hours.
  assign min_carry = min_wrap & sec_carry;
  assign hour_step = min_carry | hour_up;

  always_comb begin
    hour_next = HOUR;
`ifdef TIME_COUNT_12H_EN
    if (HOUR >= HOUR_MAX_12)
      hour_next = HOUR_MIN_12;
    else
      hour_next = bcd_inc(HOUR, 4'd1);
`else
    if (HOUR >= HOUR_MAX_24)
      hour_next = 8'h00;
    else
      hour_next = bcd_inc(HOUR, 4'd2);
`endif
  end

  always_ff @(posedge CLK or negedge RESETL) begin
    if (!RESETL) begin
      HOUR      <= HOUR_RESET;
      CARRY_DAY <= 1'b0;
    end else begin
      CARRY_DAY <= hour_step & min_carry & (hour_next == HOUR_DAY);
      if (hour_step)
        HOUR <= hour_next;
    end
  end

endmodule
